xbar_pkt_sched: RTL and testbench
=================================

XBAR_PKT_SCHED -- requirements
Module: xbar_pkt_sched

Interface
REQ-001 SHALL provide parameter PORT_NUM, default 10, number of crossbar input ports.
REQ-002 SHALL provide parameter TIMEOUT_CYC, default 4096, maximum stall cycles allowed while a grant is held.
REQ-003 SHALL provide parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL use i_clk, input, 1, as the single clock; all logic on the rising edge.
REQ-005 SHALL use i_rst, input, 1, synchronous active-high reset.
REQ-006 SHALL provide i_req, input, PORT_NUM, per-port packet-pending request (level).
REQ-007 SHALL provide i_express, input, PORT_NUM, per-port express (qbu critical) flag, valid with i_req.
REQ-008 SHALL provide i_sel_vld, input, 1, beat valid from the currently muxed port.
REQ-009 SHALL provide i_sel_last, input, 1, last beat of the packet, qualified by i_sel_vld.
REQ-010 SHALL provide i_fifo_ready, input, 1, output FIFO can accept a beat (1 = free).
REQ-011 SHALL provide o_grant, output, PORT_NUM, one-hot granted port (mux select).
REQ-012 SHALL provide o_grant_vld, output, 1, o_grant is active and beats may transfer.
REQ-013 SHALL provide o_grant_express, output, 1, current grant came from the express class.
REQ-014 SHALL provide o_timeout, output, 1, one-cycle pulse when a grant is aborted by stall timeout.
REQ-015 SHALL provide o_busy, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL define a beat transfer as o_grant_vld & i_sel_vld & i_fifo_ready in the same cycle.
REQ-017 SHALL implement FSM states IDLE, ARB, GRANT, RELEASE.
REQ-018 SHALL leave IDLE for ARB when i_fifo_ready=1 and i_req≠0; stay in IDLE otherwise.
REQ-019 SHALL in IDLE register a snapshot of i_req and i_req & i_express; ARB arbitrates on the snapshot only.
REQ-020 SHALL in ARB select the express class when the express snapshot is nonzero, otherwise the normal class.
REQ-021 SHALL arbitrate each class round-robin: first set bit at or above that class's pointer, wrapping from PORT_NUM-1 to 0.
REQ-022 SHALL keep separate express and normal pointers; only the winning class's pointer moves, to winner+1 mod PORT_NUM, in RELEASE.
REQ-023 SHALL go ARB→GRANT unconditionally, driving o_grant/o_grant_vld/o_grant_express registered from GRANT entry (request-to-grant latency 2 cycles from the IDLE sample edge).
REQ-024 SHALL hold o_grant constant through GRANT regardless of later i_req/i_express changes, including deassertion by the granted port.
REQ-025 SHALL leave GRANT for RELEASE on a transfer with i_sel_last=1; that last beat is accepted while o_grant_vld=1.
REQ-026 SHALL count GRANT cycles without a transfer, clearing on every transfer; on reaching TIMEOUT_CYC, pulse o_timeout and go to RELEASE.
REQ-027 SHALL saturate the stall counter and never wrap; TIMEOUT_CYC must be < 2^CNT_W.
REQ-028 SHALL deassert o_grant_vld and clear o_grant in RELEASE, then return to IDLE the next cycle (minimum one idle cycle between packets).
REQ-029 SHALL treat simultaneous last-beat transfer and timeout as normal completion: no o_timeout pulse.
REQ-030 SHALL, with a single requester, re-grant the same port each packet (pointer wrap permitted).

Reset
REQ-031 SHALL on i_rst=1 force state IDLE, o_grant=0, o_grant_vld=0, o_grant_express=0, o_timeout=0, o_busy=0, both pointers=0, counter=0, snapshots=0.
REQ-032 SHALL abort any grant immediately on reset mid-packet; no RELEASE pass or pointer update.

Structure
REQ-033 SHALL place FSM state encoding and default PORT_NUM/TIMEOUT_CYC constants in shared package xbar_pkg.
REQ-034 SHALL instantiate sub-module rr_pick twice (express, normal): combinational mask + pointer → one-hot winner + found flag.

Verification
REQ-035 SHALL verify: i_req=0x004, ready=1, 3-beat packet → o_grant=0x004 two cycles after sample, released after last beat, pointer_n=3.
REQ-036 SHALL verify: i_req=0x3FF, no express, four packets → grants 0x001,0x002,0x004,0x008 in order.
REQ-037 SHALL verify: i_req=0x3FF, i_express=0x020 → grant 0x020 with o_grant_express=1 before any normal port.
REQ-038 SHALL verify: granted port stalls i_sel_vld=0 for TIMEOUT_CYC=16 → o_timeout one pulse at 16th stall cycle, then IDLE.
REQ-039 SHALL verify: i_fifo_ready=0 in IDLE with i_req=0x001 → no grant until ready rises; ready dropping mid-packet holds grant, no beat lost.
REQ-040 SHALL verify: i_rst asserted mid-GRANT → all outputs 0 next cycle, next arbitration starts from port 0.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared constants for the crossbar packet scheduler: FSM encoding and default sizing.
package xbar_pkg;

  localparam int PORT_NUM_DEF    = 10;
  localparam int TIMEOUT_CYC_DEF = 4096;
  localparam int CNT_W_DEF       = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARB     = 2'd1;
  localparam logic [1:0] ST_GRANT   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of mask at or above ptr, wrapping to bit 0.
module rr_pick #(
  parameter int N  = 10,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          found
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick_src;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) begin
      hi_mask[i] = (PW'(i) >= ptr);
    end
    masked   = mask & hi_mask;
    // nothing at/above the pointer means the search wraps to the lowest set bit
    pick_src = (masked != '0) ? masked : mask;
    winner   = pick_src & (~pick_src + N'(1));
    found    = |mask;
  end

endmodule

// File: rtl/xbar_pkt_sched.sv
// Crossbar packet scheduler: snapshot requests, pick express-first round-robin, hold the
// grant for one packet, abort on stall timeout, then release with one idle cycle.
module xbar_pkt_sched
  import xbar_pkg::*;
#(
  parameter int PORT_NUM    = PORT_NUM_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [PORT_NUM-1:0] i_req,
  input  logic [PORT_NUM-1:0] i_express,
  input  logic                i_sel_vld,
  input  logic                i_sel_last,
  input  logic                i_fifo_ready,
  output logic [PORT_NUM-1:0] o_grant,
  output logic                o_grant_vld,
  output logic                o_grant_express,
  output logic                o_timeout,
  output logic                o_busy
);

  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  logic [1:0]          state;
  logic [PORT_NUM-1:0] req_snap;
  logic [PORT_NUM-1:0] exp_snap;
  logic [PORT_NUM-1:0] win_e;
  logic [PORT_NUM-1:0] win_n;
  logic [PORT_NUM-1:0] arb_grant;
  logic                found_e;
  logic                found_n;
  logic [PW-1:0]       ptr_e;
  logic [PW-1:0]       ptr_n;
  logic [PW-1:0]       arb_idx;
  logic [PW-1:0]       win_idx;
  logic [PW-1:0]       next_ptr;
  logic                win_exp;
  logic [CNT_W-1:0]    stall_cnt;
  logic                xfer;
  logic                stall_hit;

  rr_pick #(.N(PORT_NUM), .PW(PW)) u_pick_express (
    .mask   (exp_snap),
    .ptr    (ptr_e),
    .winner (win_e),
    .found  (found_e)
  );

  rr_pick #(.N(PORT_NUM), .PW(PW)) u_pick_normal (
    .mask   (req_snap),
    .ptr    (ptr_n),
    .winner (win_n),
    .found  (found_n)
  );

  assign arb_grant = found_e ? win_e : win_n;
  assign xfer      = o_grant_vld & i_sel_vld & i_fifo_ready;
  assign stall_hit = (stall_cnt >= CNT_W'(TIMEOUT_CYC - 1));
  assign o_busy    = (state != ST_IDLE);
  assign next_ptr  = (win_idx == PW'(PORT_NUM - 1)) ? '0 : win_idx + PW'(1);

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (arb_grant[i]) arb_idx = PW'(i);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= ST_IDLE;
      req_snap        <= '0;
      exp_snap        <= '0;
      ptr_e           <= '0;
      ptr_n           <= '0;
      win_idx         <= '0;
      win_exp         <= 1'b0;
      stall_cnt       <= '0;
      o_grant         <= '0;
      o_grant_vld     <= 1'b0;
      o_grant_express <= 1'b0;
      o_timeout       <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_fifo_ready && (i_req != '0)) begin
            req_snap <= i_req;
            exp_snap <= i_req & i_express;
            state    <= ST_ARB;
          end
        end
        ST_ARB: begin
          o_grant         <= arb_grant;
          o_grant_vld     <= found_e | found_n;
          o_grant_express <= found_e;
          win_idx         <= arb_idx;
          win_exp         <= found_e;
          stall_cnt       <= '0;
          state           <= ST_GRANT;
        end
        ST_GRANT: begin
          // a transfer always wins over the timeout, so a last beat on the limit completes normally
          if (xfer) begin
            stall_cnt <= '0;
            if (i_sel_last) begin
              o_grant         <= '0;
              o_grant_vld     <= 1'b0;
              o_grant_express <= 1'b0;
              state           <= ST_RELEASE;
            end
          end else if (stall_hit) begin
            o_timeout       <= 1'b1;
            o_grant         <= '0;
            o_grant_vld     <= 1'b0;
            o_grant_express <= 1'b0;
            state           <= ST_RELEASE;
          end else if (stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (win_exp) ptr_e <= next_ptr;
          else         ptr_n <= next_ptr;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xbar_pkt_sched.sv
// Randomized bench for xbar_pkt_sched against a queue-free round-robin reference model.
module tb_xbar_pkt_sched;

  localparam int P  = 10;
  localparam int TO = 16;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [P-1:0] i_req;
  logic [P-1:0] i_express;
  logic         i_sel_vld;
  logic         i_sel_last;
  logic         i_fifo_ready;
  logic [P-1:0] o_grant;
  logic         o_grant_vld;
  logic         o_grant_express;
  logic         o_timeout;
  logic         o_busy;

  int n_chk  = 0;
  int n_pass = 0;
  int m_ptr_e = 0;
  int m_ptr_n = 0;

  xbar_pkt_sched #(.PORT_NUM(P), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_req           (i_req),
    .i_express       (i_express),
    .i_sel_vld       (i_sel_vld),
    .i_sel_last      (i_sel_last),
    .i_fifo_ready    (i_fifo_ready),
    .o_grant         (o_grant),
    .o_grant_vld     (o_grant_vld),
    .o_grant_express (o_grant_express),
    .o_timeout       (o_timeout),
    .o_busy          (o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // First requesting port at or after ptr, circularly.
  function automatic logic [P-1:0] rr_ref(input logic [P-1:0] m, input int ptr);
    logic [P-1:0] r;
    r = '0;
    for (int k = 0; k < P; k++) begin
      if (m[(ptr + k) % P]) begin
        r[(ptr + k) % P] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic do_reset();
    i_rst = 1'b1;
    i_req = '0; i_express = '0; i_sel_vld = 1'b0; i_sel_last = 1'b0; i_fifo_ready = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    m_ptr_e = 0;
    m_ptr_n = 0;
  endtask

  // mode 0: back-to-back beats, 1: random vld/ready gaps, 2: stall until timeout
  task automatic run_pkt(input logic [P-1:0] req, input logic [P-1:0] exp, input int nbeats,
                         input int mode, input int idle_hold);
    logic [P-1:0] eg;
    logic         ee;
    int           lat, beats, stall, cyc, widx;
    bit           fin, tmo, vld, rdy;
    if ((req & exp) != '0) begin eg = rr_ref(req & exp, m_ptr_e); ee = 1'b1; end
    else                   begin eg = rr_ref(req, m_ptr_n);       ee = 1'b0; end

    i_req = req; i_express = exp; i_sel_vld = 1'b0; i_sel_last = 1'b0;
    i_fifo_ready = (idle_hold == 0);
    for (int k = 0; k < idle_hold; k++) begin
      tick();
      chk("nordy_vld", 32'(o_grant_vld), 0);
      chk("nordy_busy", 32'(o_busy), 0);
    end
    i_fifo_ready = 1'b1;
    lat = 0;
    while (!o_grant_vld && lat < 20) begin
      tick();
      lat++;
    end
    chk("latency", lat, 2);
    chk("grant", 32'(o_grant), 32'(eg));
    chk("grant_express", 32'(o_grant_express), 32'(ee));

    beats = 0; stall = 0; cyc = 0; fin = 0; tmo = 0;
    while (!fin && cyc < 300) begin
      if (mode == 0)      begin vld = 1'b1; rdy = 1'b1; end
      else if (mode == 1) begin
        vld = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 3) != 0);
        if (stall >= 10) begin vld = 1'b1; rdy = 1'b1; end
      end else begin
        vld = 1'b0; rdy = 1'($urandom_range(0, 1));
      end
      i_sel_vld = vld; i_fifo_ready = rdy; i_sel_last = (beats == nbeats - 1);
      i_req = P'($urandom); i_express = P'($urandom);
      tick();
      cyc++;
      if (vld && rdy) begin
        beats++;
        stall = 0;
        if (beats == nbeats) fin = 1;
      end else begin
        stall++;
        if (stall == TO) begin fin = 1; tmo = 1; end
      end
      if (!fin) begin
        chk("hold_grant", 32'(o_grant), 32'(eg));
        chk("hold_vld", 32'(o_grant_vld), 1);
        chk("no_timeout", 32'(o_timeout), 0);
      end
    end
    chk("beat_budget", 32'(fin), 1);
    chk("rel_vld", 32'(o_grant_vld), 0);
    chk("rel_grant", 32'(o_grant), 0);
    chk("rel_express", 32'(o_grant_express), 0);
    chk("rel_busy", 32'(o_busy), 1);
    chk("rel_timeout", 32'(o_timeout), 32'(tmo));

    i_sel_vld = 1'b0; i_sel_last = 1'b0; i_req = '0; i_express = '0; i_fifo_ready = 1'b1;
    tick();
    chk("idle_busy", 32'(o_busy), 0);
    chk("idle_timeout", 32'(o_timeout), 0);

    widx = 0;
    for (int i = 0; i < P; i++) if (eg[i]) widx = i;
    if (ee) m_ptr_e = (widx + 1) % P;
    else    m_ptr_n = (widx + 1) % P;
  endtask

  initial begin
    logic [P-1:0] rq, ex;
    int           md;

    do_reset();
    chk("rst_grant", 32'(o_grant), 0);
    chk("rst_vld", 32'(o_grant_vld), 0);
    chk("rst_express", 32'(o_grant_express), 0);
    chk("rst_timeout", 32'(o_timeout), 0);
    chk("rst_busy", 32'(o_busy), 0);

    // single port, 3 beats; the follow-up shows the normal pointer moved to 3
    run_pkt(10'h004, 10'h000, 3, 0, 0);
    run_pkt(10'h00F, 10'h000, 1, 0, 0);

    do_reset();
    for (int k = 0; k < 4; k++) run_pkt(10'h3FF, 10'h000, 2, 0, 0);

    run_pkt(10'h3FF, 10'h020, 2, 0, 0);
    run_pkt(10'h3FF, 10'h000, 1, 0, 0);

    run_pkt(10'h002, 10'h000, 3, 2, 0);
    run_pkt(10'h001, 10'h000, 4, 1, 5);
    run_pkt(10'h001, 10'h000, 2, 1, 0);

    for (int n = 0; n < 40; n++) begin
      rq = P'($urandom_range(1, (1 << P) - 1));
      ex = ($urandom_range(0, 2) == 0) ? P'($urandom) : '0;
      md = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      run_pkt(rq, ex, int'($urandom_range(1, 5)), md, int'($urandom_range(0, 1)) * 3);
    end

    // reset in the middle of a granted packet
    i_req = 10'h3FF; i_express = '0; i_fifo_ready = 1'b1; i_sel_vld = 1'b0; i_sel_last = 1'b0;
    tick();
    tick();
    chk("mid_pre_vld", 32'(o_grant_vld), 1);
    i_sel_vld = 1'b1;
    tick();
    i_rst = 1'b1;
    i_sel_vld = 1'b0;
    tick();
    chk("mid_rst_grant", 32'(o_grant), 0);
    chk("mid_rst_vld", 32'(o_grant_vld), 0);
    chk("mid_rst_express", 32'(o_grant_express), 0);
    chk("mid_rst_timeout", 32'(o_timeout), 0);
    chk("mid_rst_busy", 32'(o_busy), 0);
    i_rst = 1'b0;
    i_req = '0;
    m_ptr_e = 0;
    m_ptr_n = 0;
    tick();
    run_pkt(10'h3FF, 10'h000, 1, 0, 0);
    run_pkt(10'h3FF, 10'h300, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
